// File: rtl/memory_access_pkg.sv
// Shared constants, state encoding and access-legality helper for the memory stage.
package memory_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTES  = DATA_W / 8;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Illegal size for the access direction, misalignment, or both enables at once.
    function automatic logic access_fault(input logic wr, input logic rd,
                                          input logic [2:0] size, input logic [1:0] off);
        logic bad;
        bad = wr & rd;
        case (size)
            SZ_B:    bad = bad;
            SZ_H:    bad = bad | off[0];
            SZ_W:    bad = bad | (|off);
            SZ_BU:   bad = bad | wr;
            SZ_HU:   bad = bad | wr | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Selects the addressed byte/halfword lane of a load word and extends it to WIDTH.
module load_align
    import memory_access_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] i_rdata,
    input  logic [1:0]       i_off,
    input  logic [2:0]       i_size,
    output logic [WIDTH-1:0] o_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = i_rdata[{i_off, 3'b000} +: 8];
        half_v = i_off[1] ? i_rdata[16 +: 16] : i_rdata[0 +: 16];
        case (i_size)
            SZ_B:    o_data = {{(WIDTH-8){byte_v[7]}}, byte_v};
            SZ_H:    o_data = {{(WIDTH-16){half_v[15]}}, half_v};
            SZ_BU:   o_data = {{(WIDTH-8){1'b0}}, byte_v};
            SZ_HU:   o_data = {{(WIDTH-16){1'b0}}, half_v};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: single-outstanding req/ack data port, store packing,
// load alignment and registered write-back outputs.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_rd,
    input  logic [WIDTH-1:0] i_rd_sel,
    input  logic             i_mem_wr_en,
    input  logic             i_mem_rd_en,
    input  logic [WIDTH-1:0] i_mem_wr_data,
    input  logic [2:0]       i_mem_rw_size,
    output logic             o_halt,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] o_rd,
    output logic [WIDTH-1:0] o_rd_sel,
    output logic             o_fault
);

    state_e           state_q, state_d;
    logic             req_q, req_d, we_q, we_d, fault_q, fault_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       size_q, size_d;
    logic [WIDTH-1:0] lat_sel_q, lat_sel_d, rd_q, rd_d, rd_sel_q, rd_sel_d;

    logic             mem_en, bad;
    logic [WIDTH-1:0] pack_wdata, ld_data;
    logic [3:0]       pack_wstrb;

    assign mem_en = i_mem_wr_en | i_mem_rd_en;
    assign bad    = mem_en & access_fault(i_mem_wr_en, i_mem_rd_en, i_mem_rw_size, i_rd[1:0]);

    // Gated by reset so a held request cannot stall execute while the stage is in reset.
    assign o_halt = reset & ((state_q == IDLE) ? (mem_en & ~bad) : ~dmem_ack);

    always_comb begin
        case (i_mem_rw_size)
            SZ_B: begin
                pack_wdata = {BYTES{i_mem_wr_data[7:0]}};
                pack_wstrb = 4'b0001 << i_rd[1:0];
            end
            SZ_H: begin
                pack_wdata = {(BYTES/2){i_mem_wr_data[15:0]}};
                pack_wstrb = i_rd[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                pack_wdata = i_mem_wr_data;
                pack_wstrb = 4'b1111;
            end
        endcase
    end

    load_align #(.WIDTH(WIDTH)) u_load_align (
        .i_rdata (dmem_rdata),
        .i_off   (off_q),
        .i_size  (size_q),
        .o_data  (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        off_d     = off_q;
        size_d    = size_q;
        lat_sel_d = lat_sel_q;
        rd_d      = rd_q;
        rd_sel_d  = rd_sel_q;
        fault_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_en) begin
                    rd_d     = i_rd;
                    rd_sel_d = i_rd_sel;
                end else if (bad) begin
                    fault_d  = 1'b1;
                    rd_d     = '0;
                    rd_sel_d = '0;
                end else begin
                    state_d   = BUSY;
                    req_d     = 1'b1;
                    we_d      = i_mem_wr_en;
                    addr_d    = {i_rd[WIDTH-1:2], 2'b00};
                    wdata_d   = pack_wdata;
                    wstrb_d   = i_mem_wr_en ? pack_wstrb : '0;
                    off_d     = i_rd[1:0];
                    size_d    = i_mem_rw_size;
                    lat_sel_d = i_rd_sel;
                    rd_sel_d  = '0;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    rd_d     = we_q ? '0 : ld_data;
                    rd_sel_d = we_q ? '0 : lat_sel_q;
                end else begin
                    rd_sel_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            off_q     <= '0;
            size_q    <= '0;
            lat_sel_q <= '0;
            rd_q      <= '0;
            rd_sel_q  <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            off_q     <= off_d;
            size_q    <= size_d;
            lat_sel_q <= lat_sel_d;
            rd_q      <= rd_d;
            rd_sel_q  <= rd_sel_d;
            fault_q   <= fault_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign o_rd       = rd_q;
    assign o_rd_sel   = rd_sel_q;
    assign o_fault    = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized checks of memory_access against a behavioural model
// with the bench acting as the data memory.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_rd, i_rd_sel, i_mem_wr_data;
    logic        i_mem_wr_en, i_mem_rd_en;
    logic [2:0]  i_mem_rw_size;
    logic        o_halt, dmem_req, dmem_we, dmem_ack, o_fault;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, o_rd, o_rd_sel;
    logic [3:0]  dmem_wstrb;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    memory_access #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .i_rd(i_rd), .i_rd_sel(i_rd_sel),
        .i_mem_wr_en(i_mem_wr_en), .i_mem_rd_en(i_mem_rd_en),
        .i_mem_wr_data(i_mem_wr_data), .i_mem_rw_size(i_mem_rw_size),
        .o_halt(o_halt), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .o_rd(o_rd), .o_rd_sel(o_rd_sel), .o_fault(o_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes, 0 for an unusable code in the given direction.
    function automatic int unsigned acc_bytes(input logic wr, input logic [2:0] sz);
        case (sz)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4, 3'd5: return wr ? 0 : (sz == 3'd4 ? 1 : 2);
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic wr, input logic rd,
                                         input logic [2:0] sz, input logic [31:0] a);
        int unsigned n;
        if (wr && rd) return 1'b1;
        n = acc_bytes(wr, sz);
        if (n == 0) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] sz);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (sz)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    task automatic drive(input logic [31:0] rd, input logic [31:0] sel, input logic wr,
                         input logic rdn, input logic [31:0] wd, input logic [2:0] sz);
        i_rd = rd; i_rd_sel = sel; i_mem_wr_en = wr; i_mem_rd_en = rdn;
        i_mem_wr_data = wd; i_mem_rw_size = sz;
    endtask

    task automatic do_op(input logic [31:0] rd, input logic [31:0] sel, input logic wr,
                         input logic rdn, input logic [31:0] wd, input logic [2:0] sz,
                         input int unsigned waits, input logic [31:0] rdata);
        logic en, bad;
        int unsigned n;
        logic [31:0] exp_addr, exp_wdata, lowmask, bubble_rd;
        logic [3:0]  exp_strb;
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(rd, sel, wr, rdn, wd, sz);
        en  = wr | rdn;
        bad = en && ref_illegal(wr, rdn, sz, rd);
        #1 check("halt_idle", {31'd0, o_halt}, {31'd0, en && !bad});
        @(posedge clk); #1;
        if (!en) begin
            check("pass_rd", o_rd, rd);
            check("pass_sel", o_rd_sel, sel);
            check("pass_fault", {31'd0, o_fault}, 0);
            check("pass_req", {31'd0, dmem_req}, 0);
        end else if (bad) begin
            check("flt_fault", {31'd0, o_fault}, 1);
            check("flt_sel", o_rd_sel, 0);
            check("flt_rd", o_rd, 0);
            check("flt_req", {31'd0, dmem_req}, 0);
            @(negedge clk);
            bubble_rd = $urandom;
            drive(bubble_rd, 0, 1'b0, 1'b0, 0, 3'd0);
            @(posedge clk); #1;
            check("flt_pulse_end", {31'd0, o_fault}, 0);
            check("bubble_sel", o_rd_sel, 0);
        end else begin
            n         = acc_bytes(wr, sz);
            exp_addr  = rd - (rd % 4);
            exp_strb  = wr ? 4'(((1 << n) - 1) << (rd % 4)) : 4'd0;
            lowmask   = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
            exp_wdata = 0;
            for (int unsigned i = 0; i < 4 / n; i++)
                exp_wdata = exp_wdata | ((wd & lowmask) << (8 * n * i));
            check("req_rise", {31'd0, dmem_req}, 1);
            check("we", {31'd0, dmem_we}, {31'd0, wr});
            check("addr", dmem_addr, exp_addr);
            check("wstrb", {28'd0, dmem_wstrb}, {28'd0, exp_strb});
            if (wr) check("wdata", dmem_wdata, exp_wdata);
            check("busy_sel", o_rd_sel, 0);
            for (int unsigned w = 0; w < waits; w++) begin
                @(negedge clk); #1;
                check("wait_halt", {31'd0, o_halt}, 1);
                check("wait_addr", dmem_addr, exp_addr);
                @(posedge clk); #1;
                check("wait_req", {31'd0, dmem_req}, 1);
                check("wait_sel", o_rd_sel, 0);
            end
            @(negedge clk);
            dmem_ack = 1'b1; dmem_rdata = rdata;
            #1 check("ack_halt", {31'd0, o_halt}, 0);
            check("ack_strb", {28'd0, dmem_wstrb}, {28'd0, exp_strb});
            @(posedge clk); #1;
            check("done_req", {31'd0, dmem_req}, 0);
            check("done_sel", o_rd_sel, wr ? 0 : sel);
            check("done_rd", o_rd, wr ? 0 : ref_load(rdata, rd, sz));
        end
    endtask

    initial begin
        reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 0;
        drive(0, 0, 1'b0, 1'b0, 0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", o_rd, 0);
        check("rst_sel", o_rd_sel, 0);
        check("rst_req", {31'd0, dmem_req}, 0);
        check("rst_halt", {31'd0, o_halt}, 0);
        check("rst_addr", dmem_addr, 0);
        @(negedge clk) reset = 1'b1;

        do_op(32'h1234, 5, 1'b0, 1'b0, 0, 3'd0, 0, 0);
        do_op(32'h103, 7, 1'b0, 1'b1, 0, 3'd0, 2, 32'h80FF_FF7F);
        do_op(32'h102, 3, 1'b0, 1'b1, 0, 3'd5, 0, 32'hBEEF_1234);
        do_op(32'h201, 4, 1'b1, 1'b0, 32'hAB, 3'd0, 1, 0);
        do_op(32'h302, 6, 1'b1, 1'b0, 32'h5555_AAAA, 3'd2, 0, 0);
        do_op(32'h400, 2, 1'b1, 1'b1, 0, 3'd2, 0, 0);
        do_op(32'hDEAD, 0, 1'b0, 1'b0, 0, 3'd0, 0, 0);

        // Reset while a load is outstanding, then a late ack.
        @(negedge clk);
        drive(32'h400, 9, 1'b0, 1'b1, 0, 3'd2);
        @(posedge clk); #1;
        check("rb_req", {31'd0, dmem_req}, 1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("rb_req_drop", {31'd0, dmem_req}, 0);
        check("rb_halt", {31'd0, o_halt}, 0);
        check("rb_strb", {28'd0, dmem_wstrb}, 0);
        check("rb_addr", dmem_addr, 0);
        check("rb_sel", o_rd_sel, 0);
        @(negedge clk);
        drive(0, 0, 1'b0, 1'b0, 0, 3'd0);
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        check("late_ack_sel", o_rd_sel, 0);
        check("late_ack_req", {31'd0, dmem_req}, 0);
        check("late_ack_rd", o_rd, 0);

        for (int unsigned k = 0; k < 300; k++) begin
            int unsigned kind;
            logic wr, rdn;
            kind = $urandom_range(0, 9);
            wr   = (kind >= 6);
            rdn  = (kind >= 3 && kind <= 5) || kind == 9;
            do_op($urandom, $urandom_range(0, 31), wr, rdn, $urandom,
                  3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline stage directly downstream of execute. It consumes execute's registered result, destination select, memory enables, store data and access size. It performs loads and stores on a single-outstanding req/ack data-memory port, stalling execute while an access is in flight. It delivers the write-back value and destination to the write-back stage, aligning and sign- or zero-extending loads and packing stores into byte strobes.

## Interface
- WIDTH, 32, datapath width; byte lanes = WIDTH/8, fixed at 4 for this block
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- i_rd  in  WIDTH  execute result: ALU value, or effective address when a memory enable is set
- i_rd_sel  in  WIDTH  destination register select; 0 = no write-back
- i_mem_wr_en  in  1  store request
- i_mem_rd_en  in  1  load request
- i_mem_wr_data  in  WIDTH  store data (rs2)
- i_mem_rw_size  in  3  funct3 size code
- o_halt  out  1  stall to execute; execute holds its outputs while 1
- dmem_req  out  1  access request; held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  WIDTH  word-aligned address, {addr[WIDTH-1:2], 2'b00}
- dmem_wdata  out  WIDTH  lane-replicated store data
- dmem_wstrb  out  4  byte strobes; 0 on loads
- dmem_ack  in  1  access complete; rdata valid this cycle for loads
- dmem_rdata  in  WIDTH  load data word
- o_rd  out  WIDTH  write-back value
- o_rd_sel  out  WIDTH  write-back destination; 0 = bubble
- o_fault  out  1  one-cycle pulse: misaligned address or illegal size

## Operation
- Size codes:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other code is illegal.
- Misaligned cases: halfword with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE and BUSY.
- IDLE, no enable set: register o_rd=i_rd and o_rd_sel=i_rd_sel. o_halt=0.
- IDLE, enable set, aligned and legal:
  - Latch address, we, wdata, size and rd_sel.
  - o_halt=1 combinationally.
  - Go to BUSY. o_rd_sel ← 0 (bubble).
- IDLE, enable set, faulty:
  - No bus access. o_fault ← 1, o_rd_sel ← 0, o_rd ← 0.
  - o_halt=0. Stay in IDLE.
- Both enables set: illegal. Handle as a fault.
- BUSY:
  - dmem_req=1, with dmem_we/addr/wdata/wstrb driven from the latch.
  - While dmem_ack=0: o_halt=1, o_rd_sel ← 0.
  - On dmem_ack=1: o_halt=0 in that same cycle, so execute advances at the next edge. Next state is IDLE.
  - Load completion: o_rd ← extended lane data, o_rd_sel ← latched rd_sel.
  - Store completion: o_rd ← 0, o_rd_sel ← 0.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word through.
- Store packing:
  - SB: wdata = {4{data[7:0]}}, wstrb = 1<<addr[1:0].
  - SH: wdata = {2{data[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = data, wstrb = 4'b1111.
- An input with i_rd_sel=0 and no enable passes through as a bubble.

## Timing
- Reset asserted (asynchronous):
  - State → IDLE.
  - o_rd, o_rd_sel, o_fault, dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata all 0.
  - o_halt=0.
- Reset mid-BUSY drops dmem_req in the same cycle. A late ack is ignored. Deassertion is used synchronized by the top level.
- ALU pass-through latency: 1 cycle.
- Memory op with ack on the first BUSY cycle: 2 cycles, occupying the stage for 2 edges. Each wait cycle adds 1.
- Handshake rules:
  - dmem_req rises only on entry to BUSY.
  - dmem_req, addr, we, wdata and wstrb stay stable until the ack cycle.
  - Ack outside BUSY is ignored.
- o_halt is combinational from state, inputs and dmem_ack. It must not depend on o_* registers.
- In the ack cycle the same instruction is still on the inputs. BUSY must not re-latch it.
- Back-to-back memory ops: the second is latched in the IDLE cycle after ack, so there is no gap on the bus beyond that one cycle.

## Structure
- Shared package holds:
  - Size-code constants (SZ_B=0, SZ_H=1, SZ_W=2, SZ_BU=4, SZ_HU=5).
  - The IDLE/BUSY state encoding.
  - BYTES=WIDTH/8.
- One sub-module, `load_align`: combinational; takes rdata, addr[1:0] and size, returns the extended result. It is reused by the write-back forwarding path.
- Store packing, FSM and output registers live in `memory_access`.

## Test plan
- ALU pass-through: i_rd=0x1234, i_rd_sel=5, no enables → next edge o_rd=0x1234, o_rd_sel=5, o_halt=0, no dmem_req.
- LB, signed byte: addr 0x103, size 0, rdata 0x80FF_FF7F, ack after 2 wait cycles →
  - o_halt high for 3 cycles, dmem_addr=0x100.
  - o_rd=0xFFFF_FF80, o_rd_sel=latched value.
- LHU, upper half: addr 0x102, rdata 0xBEEF_1234, immediate ack → o_rd=0x0000_BEEF after 2 edges.
- SB: addr 0x201, data 0xAB → dmem_we=1, wstrb=4'b0010, wdata=0xABAB_ABAB, then o_rd_sel=0.
- Misaligned SW: addr 0x302 → o_fault pulses 1 cycle, no dmem_req, o_halt=0, o_rd_sel=0.
- Reset while BUSY: dmem_req drops immediately, all outputs 0. An ack 1 cycle later produces no write-back.
